// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with debounce, one key code per press.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scanner #(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CNT = 8,
   parameter int REPEAT_DELAY = 250,
   parameter int REPEAT_RATE  = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      HELD
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         row_meta_q, rs_q;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [3:0]         col_q, col_d, col_rot;
   logic [3:0]         cand_q, cand_d;
   logic [CNT_W-1:0]   deb_q, deb_d;
   logic [CNT_W-1:0]   rel_q, rel_d;
   logic               pend_q, pend_d;
   logic [3:0]         key_code_q;
   logic               key_valid_q;
   logic               key_held_q;
   logic               tick, any_low, accept, release_key;
   logic [1:0]         row_idx, col_idx;
   logic [3:0]         code;

   assign tick    = (div_q == DIV_W'(SCAN_DIV - 1));
   assign div_d   = tick ? '0 : div_q + DIV_W'(1);
   assign any_low = (rs_q != 4'hF);
   assign col_rot = {col_q[2:0], col_q[3]};
   assign code    = {row_idx, col_idx};

   // Lowest pressed row wins when several rows are low.
   always_comb begin
      casez (rs_q)
         4'b???0: row_idx = 2'd0;
         4'b??01: row_idx = 2'd1;
         4'b?011: row_idx = 2'd2;
         default: row_idx = 2'd3;
      endcase
   end

   always_comb begin
      case (col_q)
         4'b1101: col_idx = 2'd1;
         4'b1011: col_idx = 2'd2;
         4'b0111: col_idx = 2'd3;
         default: col_idx = 2'd0;
      endcase
   end

   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      state_d     = state_q;
      col_d       = col_q;
      cand_d      = cand_q;
      deb_d       = deb_q;
      rel_d       = rel_q;
      accept      = 1'b0;
      release_key = 1'b0;
      case (state_q)
         SCAN: begin
            if (tick) begin
               if (!any_low) begin
                  col_d = col_rot;
               end else begin
                  cand_d = code;
                  deb_d  = CNT_W'(1);
                  if (DEBOUNCE_CNT == 1) begin
                     accept  = 1'b1;
                     rel_d   = '0;
                     state_d = HELD;
                  end else begin
                     state_d = DEBOUNCE;
                  end
               end
            end
         end
         DEBOUNCE: begin
            if (tick) begin
               if (any_low && (code == cand_q)) begin
                  if (deb_q == CNT_W'(DEBOUNCE_CNT - 1)) begin
                     accept  = 1'b1;
                     rel_d   = '0;
                     state_d = HELD;
                  end else begin
                     deb_d = deb_q + CNT_W'(1);
                  end
               end else begin
                  col_d   = col_rot;
                  state_d = SCAN;
               end
            end
         end
         HELD: begin
            if (tick) begin
               if (any_low) begin
                  rel_d = '0;
               end else if (rel_q == CNT_W'(DEBOUNCE_CNT - 1)) begin
                  rel_d       = '0;
                  release_key = 1'b1;
                  col_d       = col_rot;
                  state_d     = SCAN;
               end else begin
                  rel_d = rel_q + CNT_W'(1);
               end
            end
         end
         default: state_d = SCAN;
      endcase
   end

`ifdef KEYPAD_REPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int REP_W   = $clog2(REP_MAX + 1);

   logic [REP_W-1:0] rep_q, rep_d;
   logic             armed_q, armed_d;
   logic             rep_fire;

   // First repeat waits REPEAT_DELAY ticks, later ones REPEAT_RATE ticks.
   always_comb begin
      rep_d    = rep_q;
      armed_d  = armed_q;
      rep_fire = 1'b0;
      if (state_q != HELD) begin
         rep_d   = '0;
         armed_d = 1'b0;
      end else if (tick) begin
         if (!any_low) begin
            rep_d = '0;
         end else if (rep_q == (armed_q ? REP_W'(REPEAT_RATE - 1) : REP_W'(REPEAT_DELAY - 1))) begin
            rep_fire = 1'b1;
            rep_d    = '0;
            armed_d  = 1'b1;
         end else begin
            rep_d = rep_q + REP_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rep_q   <= '0;
         armed_q <= 1'b0;
      end else begin
         rep_q   <= rep_d;
         armed_q <= armed_d;
      end
   end

   assign pend_d = accept | rep_fire;
`else
   assign pend_d = accept;
`endif

   // Accept decisions are registered once more so key_valid lands one cycle after the tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_meta_q  <= 4'hF;
         rs_q        <= 4'hF;
         div_q       <= '0;
         state_q     <= SCAN;
         col_q       <= 4'b1110;
         cand_q      <= '0;
         deb_q       <= '0;
         rel_q       <= '0;
         pend_q      <= 1'b0;
         key_code_q  <= '0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         row_meta_q  <= row_in;
         rs_q        <= row_meta_q;
         div_q       <= div_d;
         state_q     <= state_d;
         col_q       <= col_d;
         cand_q      <= cand_d;
         deb_q       <= deb_d;
         rel_q       <= rel_d;
         pend_q      <= pend_d;
         key_valid_q <= pend_q;
         if (pend_q) begin
            key_code_q <= cand_q;
            key_held_q <= 1'b1;
         end else if (release_key) begin
            key_held_q <= 1'b0;
         end
      end
   end

   assign col_out   = col_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 keypad on the column/row wires.
// Cycle numbers in comments count posedges since the last reset release.
module tb_keypad_scanner;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  row_in;
   logic [3:0]  col_out;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
   logic [15:0] key_mask;

   int checks = 0;
   int errors = 0;
   int pulses;
   int consec;
   logic prev_valid;

`ifdef KEYPAD_REPEAT_EN
   localparam int EXP_REPEATS = 8;
`else
   localparam int EXP_REPEATS = 0;
`endif

   keypad_scanner #(
      .SCAN_DIV    (4),
      .DEBOUNCE_CNT(3),
      .REPEAT_DELAY(5),
      .REPEAT_RATE (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .row_in   (row_in),
      .col_out  (col_out),
      .key_code (key_code),
      .key_valid(key_valid),
      .key_held (key_held)
   );

   always #5 clk = ~clk;

   // Pressed key (r,c) pulls row r low while column c is driven low.
   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (key_mask[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst      = 1'b1;
      key_mask = '0;
      step(2);
      check("rst_col", col_out, 4'b1110);
      check("rst_code", key_code, 4'd0);
      check("rst_valid", key_valid, 1'b0);
      check("rst_held", key_held, 1'b0);
      rst = 1'b0;                                   // c=0

      step(3);  check("rot_pre", col_out, 4'b1110);  // c=3
      step(1);  check("rot_1", col_out, 4'b1101);    // c=4

      // Key 9 (row2,col1); detecting tick at c=8, pulse expected at c=17.
      key_mask[9] = 1'b1;
      step(12);                                      // c=16
      check("k9_early", key_valid, 1'b0);
      check("k9_col_frozen", col_out, 4'b1101);
      step(1);                                       // c=17
      check("k9_valid", key_valid, 1'b1);
      check("k9_code", key_code, 4'd9);
      check("k9_held", key_held, 1'b1);
      step(1);                                       // c=18
      check("k9_one_cycle", key_valid, 1'b0);

      pulses = 0; consec = 0; prev_valid = 1'b0;
      for (int i = 0; i < 79; i++) begin             // c=19..97
         step(1);
         if (key_valid) pulses++;
         if (key_valid && prev_valid) consec++;
         prev_valid = key_valid;
      end
      check("hold_repeats", pulses, EXP_REPEATS);
      check("hold_no_back2back", consec, 0);
      check("hold_code", key_code, 4'd9);
      check("hold_col", col_out, 4'b1101);

      // Release: all-high ticks at c=100,104,108.
      key_mask = '0;                                 // c=97
      step(10);                                      // c=107
      check("rel_held_pre", key_held, 1'b1);
      check("rel_col_pre", col_out, 4'b1101);
      step(1);                                       // c=108
      check("rel_held", key_held, 1'b0);
      check("rel_col", col_out, 4'b1011);
      check("rel_code", key_code, 4'd9);

      // Bounce: key 6 seen on ticks 112,116, gone by tick 120.
      key_mask[6] = 1'b1;
      pulses = 0;
      for (int i = 0; i < 9; i++) begin              // c=109..117
         step(1);
         if (key_valid) pulses++;
      end
      key_mask = '0;
      step(2);                                       // c=119
      check("bounce_col_frozen", col_out, 4'b1011);
      step(1);                                       // c=120
      check("bounce_col_resume", col_out, 4'b0111);
      check("bounce_no_valid", pulses, 0);
      check("bounce_code", key_code, 4'd9);
      check("bounce_held", key_held, 1'b0);

      // Rows 0 and 3 in column 2: detect at 136, pulse at 145.
      step(12);                                      // c=132
      check("multi_col", col_out, 4'b1011);
      key_mask[2]  = 1'b1;
      key_mask[14] = 1'b1;
      step(12);                                      // c=144
      check("multi_early", key_valid, 1'b0);
      step(1);                                       // c=145
      check("multi_valid", key_valid, 1'b1);
      check("multi_code", key_code, 4'd2);
      key_mask = '0;
      step(11);                                      // c=156
      check("multi_rel_col", col_out, 4'b0111);
      check("multi_rel_held", key_held, 1'b0);

      // Key 15 detected at tick 160, reset lands during DEBOUNCE.
      key_mask[15] = 1'b1;
      step(6);                                       // c=162
      rst = 1'b1;
      key_mask = '0;
      step(2);
      check("mid_rst_col", col_out, 4'b1110);
      check("mid_rst_valid", key_valid, 1'b0);
      check("mid_rst_code", key_code, 4'd0);
      check("mid_rst_held", key_held, 1'b0);
      rst = 1'b0;                                    // c=0
      pulses = 0;
      for (int i = 0; i < 16; i++) begin
         step(1);
         if (key_valid) pulses++;
      end
      check("mid_rst_no_pulse", pulses, 0);
      check("mid_rst_col_wrap", col_out, 4'b1110);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
